// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// uart_tx_sched_if : producer / transmitter bundle for the UART TX scheduler
// Revision 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_start;
  logic                      tx_busy;
  logic                      tx_done;
  logic [ID_W-1:0]           grant_id;
  logic                      grant_active;

  // Producers and the transmitter sit on the master side.
  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_data, tx_start, grant_id, grant_active
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_data, tx_start, grant_id, grant_active
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// uart_tx_sched : round-robin scheduler sharing one UART transmitter
// Revision 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_sched_if.slave    bus
);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int HOLD_W  = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
  localparam logic [HOLD_W-1:0]  HOLD_LIMIT = HOLD_W'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t              state_q,        state_d;
  logic [ID_W-1:0]     rr_ptr_q,       rr_ptr_d;
  logic [ID_W-1:0]     grant_id_q,     grant_id_d;
  logic                grant_active_q, grant_active_d;
  logic [BURST_W-1:0]  burst_cnt_q,    burst_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q,     hold_cnt_d;
  logic                last_seen_q,    last_seen_d;
  logic [DATA_W-1:0]   tx_data_q,      tx_data_d;
  logic                tx_start_q,     tx_start_d;

  logic [NUM_REQ-1:0]  req_ready_w;
  logic [ID_W-1:0]     pick_id_w;
  logic                pick_found_w;
  logic [DATA_W-1:0]   sel_data_w;
  logic [ID_W-1:0]     next_ptr_w;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    idx          = 0;
    pick_id_w    = '0;
    pick_found_w = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found_w && bus.req_valid[ID_W'(idx)]) begin
        pick_found_w = 1'b1;
        pick_id_w    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_data_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) sel_data_w = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign next_ptr_w = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    burst_cnt_d    = burst_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    last_seen_d    = last_seen_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    req_ready_w    = '0;

    case (state_q)
      IDLE: begin
        if (pick_found_w) begin
          grant_id_d     = pick_id_w;
          grant_active_d = 1'b1;
          burst_cnt_d    = '0;
          hold_cnt_d     = '0;
          state_d        = ISSUE;
        end
      end

      // A busy transmitter freezes the idle-hold timer as well as the issue.
      ISSUE: begin
        if (!bus.tx_busy) begin
          if (bus.req_valid[grant_id_q]) begin
            req_ready_w[grant_id_q] = 1'b1;
            tx_data_d   = sel_data_w;
            tx_start_d  = 1'b1;
            burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
            last_seen_d = bus.req_last[grant_id_q];
            hold_cnt_d  = '0;
            state_d     = WAIT_DONE;
          end else if (hold_cnt_q == HOLD_LIMIT) begin
            rr_ptr_d       = next_ptr_w;
            grant_active_d = 1'b0;
            hold_cnt_d     = '0;
            state_d        = IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (last_seen_q || (burst_cnt_q == BURST_MAX)) begin
            rr_ptr_d       = next_ptr_w;
            grant_active_d = 1'b0;
            state_d        = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      default: begin
        grant_active_d = 1'b0;
        state_d        = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      burst_cnt_q    <= '0;
      hold_cnt_q     <= '0;
      last_seen_q    <= 1'b0;
      tx_data_q      <= '0;
      tx_start_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      burst_cnt_q    <= burst_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      last_seen_q    <= last_seen_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
    end
  end

  assign bus.req_ready    = req_ready_w;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = grant_active_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_sched : directed self-checking bench for uart_tx_sched
// Revision 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_tx_sched_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_sched #(
    .NUM_REQ(4), .DATA_W(8), .MAX_BURST(16), .HOLD_TIMEOUT(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    bus.req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a launch and reports the byte and current grant.
  task automatic wait_start(output logic [7:0] d, output logic [1:0] g);
    int n;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("tx_start_seen", 32'(bus.tx_start), 32'd1);
    d = bus.tx_data;
    g = bus.grant_id;
  endtask

  task automatic finish_frame();
    bus.tx_busy = 1'b1;
    tick();
    tick();
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] g;
    checks = 0;
    errors = 0;

    // Reset state
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
    chk("rst_grant_active", 32'(bus.grant_active), 32'h0);
    rst = 1'b0;
    tick();

    // 1. Single requester, then rr_ptr observed through the next arbitration
    bus.req_valid = 4'b0001;
    set_byte(0, 8'h0C);
    bus.req_last = 4'b0001;
    #1;
    chk("t1_ready_before_grant", 32'(bus.req_ready), 32'h0);
    tick();
    chk("t1_grant_active", 32'(bus.grant_active), 32'h1);
    chk("t1_grant_id", 32'(bus.grant_id), 32'h0);
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    chk("t1_no_start_yet", 32'(bus.tx_start), 32'h0);
    tick();
    chk("t1_tx_start", 32'(bus.tx_start), 32'h1);
    chk("t1_tx_data", 32'(bus.tx_data), 32'h0C);
    chk("t1_ready_dropped", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 4'b0000;
    tick();
    chk("t1_start_pulse_end", 32'(bus.tx_start), 32'h0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t1_released", 32'(bus.grant_active), 32'h0);
    bus.req_valid = 4'b0011;
    set_byte(1, 8'h21);
    bus.req_last = 4'b0011;
    tick();
    chk("t1_rr_ptr_1", 32'(bus.grant_id), 32'h1);
    wait_start(d, g);
    chk("t1_req1_data", 32'(d), 32'h21);
    bus.req_valid = 4'b0000;
    finish_frame();

    // 2. Round robin across four single-byte producers
    do_reset();
    for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i));
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(d, g);
      chk("t2_rr_data", 32'(d), 32'(8'h10 + (k % 4)));
      chk("t2_rr_grant", 32'(g), 32'(k % 4));
      if (k == 4) bus.req_valid = 4'b0000;
      finish_frame();
    end

    // 3. Burst cap on a long stream from req1 with req2 waiting
    do_reset();
    bus.req_last  = 4'b0100;
    set_byte(1, 8'h30);
    set_byte(2, 8'h50);
    bus.req_valid = 4'b0110;
    for (int k = 0; k < 16; k++) begin
      wait_start(d, g);
      chk("t3_burst_data", 32'(d), 32'(8'h30 + k));
      chk("t3_burst_grant", 32'(g), 32'h1);
      set_byte(1, 8'(8'h30 + k + 1));
      finish_frame();
    end
    wait_start(d, g);
    chk("t3_rotate_grant", 32'(g), 32'h2);
    chk("t3_rotate_data", 32'(d), 32'h50);
    bus.req_valid = 4'b0010;
    finish_frame();
    for (int k = 16; k < 20; k++) begin
      wait_start(d, g);
      chk("t3_resume_data", 32'(d), 32'(8'h30 + k));
      chk("t3_resume_grant", 32'(g), 32'h1);
      set_byte(1, 8'(8'h30 + k + 1));
      if (k == 18) bus.req_last = 4'b0010;
      if (k == 19) bus.req_valid = 4'b0000;
      finish_frame();
    end
    chk("t3_final_release", 32'(bus.grant_active), 32'h0);

    // 4. Hold timeout after req3 drops valid mid-message
    do_reset();
    bus.req_valid = 4'b1000;
    set_byte(3, 8'h77);
    bus.req_last = 4'b0000;
    wait_start(d, g);
    chk("t4_req3_grant", 32'(g), 32'h3);
    bus.req_valid = 4'b0001;
    set_byte(0, 8'h0A);
    bus.req_last = 4'b0001;
    finish_frame();
    for (int k = 0; k < 63; k++) tick();
    chk("t4_still_held", 32'(bus.grant_active), 32'h1);
    chk("t4_still_req3", 32'(bus.grant_id), 32'h3);
    chk("t4_no_ready_other", 32'(bus.req_ready), 32'h0);
    tick();
    chk("t4_timeout_release", 32'(bus.grant_active), 32'h0);
    tick();
    chk("t4_req0_grant", 32'(bus.grant_id), 32'h0);
    chk("t4_req0_active", 32'(bus.grant_active), 32'h1);
    wait_start(d, g);
    chk("t4_req0_data", 32'(d), 32'h0A);
    bus.req_valid = 4'b0000;
    finish_frame();

    // 5. Stray done in IDLE, then tx_busy blocking issue and the hold timer
    do_reset();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t5_stray_active", 32'(bus.grant_active), 32'h0);
    chk("t5_stray_start", 32'(bus.tx_start), 32'h0);
    bus.tx_busy   = 1'b1;
    bus.req_valid = 4'b0001;
    set_byte(0, 8'h5A);
    bus.req_last  = 4'b0001;
    tick();
    chk("t5_grant_busy", 32'(bus.grant_active), 32'h1);
    chk("t5_ready_busy", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 4'b0000;
    for (int k = 0; k < 70; k++) tick();
    chk("t5_no_timeout_busy", 32'(bus.grant_active), 32'h1);
    bus.req_valid = 4'b0001;
    #1;
    chk("t5_ready_still_busy", 32'(bus.req_ready), 32'h0);
    bus.tx_busy = 1'b0;
    #1;
    chk("t5_ready_after_busy", 32'(bus.req_ready), 32'h1);
    tick();
    chk("t5_start", 32'(bus.tx_start), 32'h1);
    chk("t5_data", 32'(bus.tx_data), 32'h5A);
    bus.req_valid = 4'b0000;
    finish_frame();
    chk("t5_release", 32'(bus.grant_active), 32'h0);
    chk("t5_data_held", 32'(bus.tx_data), 32'h5A);

    // 6. Asynchronous reset during WAIT_DONE
    do_reset();
    bus.req_valid = 4'b0010;
    set_byte(1, 8'h99);
    bus.req_last  = 4'b0110;
    wait_start(d, g);
    bus.req_valid = 4'b0000;
    finish_frame();
    bus.req_valid = 4'b0100;
    set_byte(2, 8'hC3);
    wait_start(d, g);
    chk("t6_pre_grant", 32'(g), 32'h2);
    bus.req_valid = 4'b0101;
    rst = 1'b1;
    #2;
    chk("t6_async_start", 32'(bus.tx_start), 32'h0);
    chk("t6_async_data", 32'(bus.tx_data), 32'h0);
    chk("t6_async_active", 32'(bus.grant_active), 32'h0);
    chk("t6_async_id", 32'(bus.grant_id), 32'h0);
    chk("t6_async_ready", 32'(bus.req_ready), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_restart_req0", 32'(bus.grant_id), 32'h0);
    chk("t6_restart_active", 32'(bus.grant_active), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
